// File: rtl/reg_wb_arbiter_pkg.sv
// Shared register-file types and the write-back request record.
package reg_wb_arbiter_pkg;
   localparam int word_size  = 8;
   localparam int reg_size   = 4;
   localparam int reg_addr_w = $clog2(reg_size);

   typedef logic [word_size-1:0]  word;
   typedef logic [reg_addr_w-1:0] regAddr;

   // One pending register write: destination and value.
   typedef struct packed {
      regAddr addr;
      word    data;
   } wb_req_t;
endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Write-back bus: producer requests, register-file write port and
// per-read-port forwarding results.
interface reg_wb_arbiter_if import reg_wb_arbiter_pkg::*; #(
   parameter int NREQ = 3
) ();
   logic   [NREQ-1:0] req_valid;
   regAddr [NREQ-1:0] req_addr;
   word    [NREQ-1:0] req_data;
   logic   [NREQ-1:0] req_ready;

   logic   wr_en;
   regAddr wr_addr;
   word    wr_data;

   regAddr rd_addr1;
   regAddr rd_addr2;
   logic   fwd1_en;
   word    fwd1_data;
   logic   fwd2_en;
   word    fwd2_data;

   // Producer / pipeline side.
   modport master (
      output req_valid, req_addr, req_data, rd_addr1, rd_addr2,
      input  req_ready, wr_en, wr_addr, wr_data,
             fwd1_en, fwd1_data, fwd2_en, fwd2_data
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_addr, req_data, rd_addr1, rd_addr2,
      output req_ready, wr_en, wr_addr, wr_data,
             fwd1_en, fwd1_data, fwd2_en, fwd2_data
   );
endinterface

// File: rtl/reg_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N.
module rr_arbiter #(
   parameter  int N  = 3,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          any_gnt
);
   int cand;

   // Scan offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      cand    = 0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = (int'(ptr) + k) % N;
         if (req[cand]) begin
            gnt_idx = IW'(cand);
            any_gnt = 1'b1;
         end
      end
      if (any_gnt) begin
         gnt[gnt_idx] = 1'b1;
      end
   end
endmodule

// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter for the single register-file write port, with
// registered read-during-write forwarding for both read ports.
module reg_wb_arbiter import reg_wb_arbiter_pkg::*; #(
   parameter int NREQ = 3
) (
   input  logic          clk,
   input  logic          rst,
   reg_wb_arbiter_if.slave bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NREQ-1:0] gnt;
   logic [IW-1:0]   gnt_idx;
   logic            any_gnt;
   logic            take;

   wb_req_t wr_q, wr_d;
   logic    wr_en_q, wr_en_d;
   logic    fwd1_en_q, fwd1_en_d, fwd2_en_q, fwd2_en_d;
   word     fwd1_data_q, fwd1_data_d, fwd2_data_q, fwd2_data_d;

   rr_arbiter #(.N(NREQ)) u_rr_arbiter (
      .req     (bus.req_valid),
      .ptr     (rr_ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any_gnt (any_gnt)
   );

   // No grants are issued while reset is held, so nothing is lost.
   assign take          = any_gnt & ~rst;
   assign bus.req_ready = rst ? '0 : gnt;

   // Next write-port contents, pointer advance and forwarding compares.
   always_comb begin
      wr_d     = wr_q;
      wr_en_d  = 1'b0;
      rr_ptr_d = rr_ptr_q;
      if (take) begin
         wr_en_d   = 1'b1;
         wr_d.addr = bus.req_addr[gnt_idx];
         wr_d.data = bus.req_data[gnt_idx];
         rr_ptr_d  = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      fwd1_en_d   = wr_en_q & (wr_q.addr == bus.rd_addr1);
      fwd2_en_d   = wr_en_q & (wr_q.addr == bus.rd_addr2);
      fwd1_data_d = wr_q.data;
      fwd2_data_d = wr_q.data;
   end

   // State registers; reset drops any in-flight write.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         wr_q        <= '0;
         wr_en_q     <= 1'b0;
         fwd1_en_q   <= 1'b0;
         fwd2_en_q   <= 1'b0;
         fwd1_data_q <= '0;
         fwd2_data_q <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         wr_q        <= wr_d;
         wr_en_q     <= wr_en_d;
         fwd1_en_q   <= fwd1_en_d;
         fwd2_en_q   <= fwd2_en_d;
         fwd1_data_q <= fwd1_data_d;
         fwd2_data_q <= fwd2_data_d;
      end
   end

   assign bus.wr_en     = wr_en_q;
   assign bus.wr_addr   = wr_q.addr;
   assign bus.wr_data   = wr_q.data;
   assign bus.fwd1_en   = fwd1_en_q;
   assign bus.fwd1_data = fwd1_data_q;
   assign bus.fwd2_en   = fwd2_en_q;
   assign bus.fwd2_data = fwd2_data_q;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios plus randomized traffic,
// checked against a behavioural model of grants, the write port, forwarding
// and the register file contents.
module tb_reg_wb_arbiter;
   import reg_wb_arbiter_pkg::*;

   localparam int NREQ = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   reg_wb_arbiter_if #(.NREQ(NREQ)) bus ();

   reg_wb_arbiter #(.NREQ(NREQ)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Stimulus for the next cycle.
   logic [NREQ-1:0] cur_valid;
   regAddr          cur_addr [NREQ];
   word             cur_data [NREQ];
   regAddr          cur_rd1, cur_rd2;
   logic            cur_rst;
   int              last_win;

   // Behavioural model state.
   int     m_ptr;
   logic   m_wr_en;
   regAddr m_wr_addr;
   word    m_wr_data;
   logic   m_fwd1_en, m_fwd2_en;
   word    m_fwd1_data, m_fwd2_data;
   word    m_regs [reg_size];
   // Register file rebuilt from the DUT's write port.
   word    b_regs [reg_size];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int winner(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   // One clock cycle: drive, check grant, model the edge, check outputs.
   task automatic step();
      int w;
      logic [NREQ-1:0] exp_ready;
      @(negedge clk);
      rst           = cur_rst;
      bus.req_valid = cur_valid;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_addr[i] = cur_addr[i];
         bus.req_data[i] = cur_data[i];
      end
      bus.rd_addr1 = cur_rd1;
      bus.rd_addr2 = cur_rd2;
      #1;
      w = cur_rst ? -1 : winner(cur_valid, m_ptr);
      exp_ready = (w < 0) ? '0 : NREQ'(1) << w;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      last_win = w;
      // Register file write at the end of this cycle (held off while in reset).
      if (!cur_rst && bus.wr_en === 1'b1) b_regs[bus.wr_addr] = bus.wr_data;
      if (!cur_rst && m_wr_en) m_regs[m_wr_addr] = m_wr_data;
      if (w >= 0) $display("grant req%0d addr=%0d data=%02h", w, cur_addr[w], cur_data[w]);
      @(posedge clk);
      #1;
      if (cur_rst) begin
         m_ptr = 0; m_wr_en = 0; m_wr_addr = '0; m_wr_data = '0;
         m_fwd1_en = 0; m_fwd2_en = 0; m_fwd1_data = '0; m_fwd2_data = '0;
      end else begin
         m_fwd1_en   = m_wr_en && (m_wr_addr == cur_rd1);
         m_fwd2_en   = m_wr_en && (m_wr_addr == cur_rd2);
         m_fwd1_data = m_wr_data;
         m_fwd2_data = m_wr_data;
         if (w >= 0) begin
            m_wr_en   = 1'b1;
            m_wr_addr = cur_addr[w];
            m_wr_data = cur_data[w];
            m_ptr     = (w + 1) % NREQ;
         end else begin
            m_wr_en = 1'b0;
         end
      end
      chk("wr_en",     32'(bus.wr_en),     32'(m_wr_en));
      chk("wr_addr",   32'(bus.wr_addr),   32'(m_wr_addr));
      chk("wr_data",   32'(bus.wr_data),   32'(m_wr_data));
      chk("fwd1_en",   32'(bus.fwd1_en),   32'(m_fwd1_en));
      chk("fwd1_data", 32'(bus.fwd1_data), 32'(m_fwd1_data));
      chk("fwd2_en",   32'(bus.fwd2_en),   32'(m_fwd2_en));
      chk("fwd2_data", 32'(bus.fwd2_data), 32'(m_fwd2_data));
   endtask

   task automatic set_req(input int i, input regAddr a, input word d);
      cur_valid[i] = 1'b1;
      cur_addr[i]  = a;
      cur_data[i]  = d;
   endtask

   initial begin
      bit hold [NREQ];
      bus.req_valid = '0;
      bus.rd_addr1  = '0;
      bus.rd_addr2  = '0;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_addr[i] = '0;
         bus.req_data[i] = '0;
         cur_addr[i]     = regAddr'(i);
         cur_data[i]     = word'(8'h10 + i);
      end
      for (int r = 0; r < reg_size; r++) begin
         m_regs[r] = '0;
         b_regs[r] = '0;
      end
      m_ptr = 0; m_wr_en = 0; m_wr_addr = '0; m_wr_data = '0;
      m_fwd1_en = 0; m_fwd2_en = 0; m_fwd1_data = '0; m_fwd2_data = '0;
      cur_rd1 = '0; cur_rd2 = '0; last_win = -1;

      // Reset held with all requesters valid, then release: 0,1,2,0,1,2.
      cur_rst = 1'b1; cur_valid = '1;
      step(); step();
      cur_rst = 1'b0;
      step();
      chk("t1_first_grant", 32'(last_win), 32'd0);
      for (int n = 0; n < 5; n++) step();
      // Requester 2 drops: 0,1,0,1 back to back.
      cur_valid[2] = 1'b0;
      for (int n = 0; n < 4; n++) begin
         step();
         chk("t3_order", 32'(last_win), 32'(n % 2));
      end

      // Single requester 1 writes A5 to register 2.
      cur_valid = '0; set_req(1, 2'd2, 8'hA5);
      step();
      chk("t2_wr_data", 32'(bus.wr_data), 32'h0A5);
      cur_valid = '0;
      step();
      chk("t2_reg2", 32'(b_regs[2]), 32'h0A5);

      // Same-address collision from pointer 0: 11 then 22.
      cur_rst = 1'b1; step(); cur_rst = 1'b0;
      cur_valid = '0; set_req(0, 2'd3, 8'h11); set_req(2, 2'd3, 8'h22);
      step();
      cur_valid[0] = 1'b0;
      step();
      cur_valid = '0;
      step(); step();
      chk("t4_reg3", 32'(b_regs[3]), 32'h022);

      // Forwarding: one port, then both ports from the same write.
      set_req(0, 2'd1, 8'h3C); cur_rd1 = 2'd1; cur_rd2 = 2'd0;
      step();
      cur_valid = '0;
      step();
      chk("t5_fwd1_en", 32'(bus.fwd1_en), 32'd1);
      chk("t5_fwd1_data", 32'(bus.fwd1_data), 32'h03C);
      chk("t5_fwd2_en", 32'(bus.fwd2_en), 32'd0);
      set_req(0, 2'd1, 8'h4D); cur_rd1 = 2'd1; cur_rd2 = 2'd1;
      step();
      cur_valid = '0;
      step();
      chk("t5_both_en", 32'({bus.fwd1_en, bus.fwd2_en}), 32'd3);
      chk("t5_both_data", 32'(bus.fwd2_data), 32'h04D);
      cur_rd1 = '0; cur_rd2 = '0;

      // Reset mid-write: the write of 77 to register 0 is dropped.
      set_req(0, 2'd0, 8'h5A);
      step();
      cur_valid = '0;
      step();
      set_req(1, 2'd0, 8'h77);
      step();
      cur_rst = 1'b1;
      step();
      chk("t6_wr_en", 32'(bus.wr_en), 32'd0);
      cur_rst = 1'b0;
      step();
      chk("t6_reg0_kept", 32'(b_regs[0]), 32'h05A);
      chk("t6_regrant", 32'(last_win), 32'd1);
      cur_valid = '0;
      step();

      // Randomized traffic; ungranted requesters hold addr/data.
      for (int i = 0; i < NREQ; i++) hold[i] = 1'b0;
      for (int n = 0; n < 250; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (hold[i]) begin
               cur_valid[i] = ($urandom_range(9) != 0);
            end else begin
               cur_valid[i] = 1'($urandom_range(1));
               cur_addr[i]  = regAddr'($urandom_range(reg_size - 1));
               cur_data[i]  = word'($urandom_range(255));
            end
         end
         cur_rd1 = regAddr'($urandom_range(reg_size - 1));
         cur_rd2 = regAddr'($urandom_range(reg_size - 1));
         cur_rst = ($urandom_range(29) == 0);
         step();
         for (int i = 0; i < NREQ; i++) hold[i] = cur_valid[i] && !cur_rst && (last_win != i);
      end
      cur_rst = 1'b0; cur_valid = '0;
      step(); step();
      for (int r = 0; r < reg_size; r++) chk("final_reg", 32'(b_regs[r]), 32'(m_regs[r]));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
